// File: rtl/pc_control_pkg.sv
// Shared definitions for the program-counter control path: PC width,
// condition-code encodings, flag bit positions and the PC state enum.
package pc_control_pkg;

    localparam int PC_W = 16;

    // Condition codes carried in the branch instruction
    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_ALWAYS = 3'b111;

    // Bit positions inside the {Z, V, N} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_control_branch_cond.sv
// Branch condition evaluator: decodes a 3-bit condition code against the
// {Z, V, N} flags. Purely combinational so later stages can reuse it.
module branch_cond
    import pc_control_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       cond_true
);

    logic flag_z;
    logic flag_v;
    logic flag_n;

    assign flag_z = flags[FLAG_Z];
    assign flag_v = flags[FLAG_V];
    assign flag_n = flags[FLAG_N];

    // Condition table lookup
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            CC_NE:     cond_true = ~flag_z;
            CC_EQ:     cond_true = flag_z;
            CC_GT:     cond_true = ~flag_z & ~flag_n;
            CC_LT:     cond_true = flag_n;
            CC_GTE:    cond_true = flag_z | (~flag_z & ~flag_n);
            CC_LTE:    cond_true = flag_n | flag_z;
            CC_OVFL:   cond_true = flag_v;
            CC_ALWAYS: cond_true = 1'b1;
            default:   cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_control.sv
// Program-counter owner: holds the fetch PC, forms PC+2 and branch targets,
// evaluates branch conditions and selects the next PC. Halt is terminal
// until reset; a taken relative branch whose target overflows sets a
// sticky flag but still uses the wrapped target.
module pc_control
    import pc_control_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch,
    input  logic            branch_reg,
    input  logic [2:0]      cond,
    input  logic [8:0]      imm9,
    input  logic [PC_W-1:0] reg_tgt,
    input  logic [2:0]      flags,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus2,
    output logic            taken,
    output logic            halted,
    output logic            tgt_ovfl
);

    pc_state_e       state_q;
    pc_state_e       state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            tgt_ovfl_q;
    logic            tgt_ovfl_d;

    logic            cond_true;
    logic [PC_W-1:0] b_offset;
    logic [PC_W-1:0] b_tgt;
    logic            b_ovfl;
    logic [PC_W-1:0] br_tgt;

    branch_cond u_branch_cond (
        .cond      (cond),
        .flags     (flags),
        .cond_true (cond_true)
    );

    assign pc_plus2 = pc_q + 16'd2;

    // Word offset: sign-extend, then scale to bytes
    assign b_offset = {{6{imm9[8]}}, imm9, 1'b0};
    assign b_tgt    = pc_plus2 + b_offset;
    // Signed overflow: like-signed operands producing an opposite-signed sum
    assign b_ovfl   = (pc_plus2[PC_W-1] == b_offset[PC_W-1]) &&
                      (b_tgt[PC_W-1] != pc_plus2[PC_W-1]);

    // Register-indirect targets are forced to a halfword boundary
    assign br_tgt = reg_tgt & ~16'h0001;

    assign taken = (branch | branch_reg) & cond_true & (state_q == RUN) & ~stall;

    // Next-state, next-PC and sticky-overflow selection in priority order
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_plus2;
        tgt_ovfl_d = tgt_ovfl_q;
        if (state_q == HALTED) begin
            pc_d = pc_q;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (halt) begin
            pc_d    = pc_q;
            state_d = HALTED;
        end else if (taken && branch_reg) begin
            pc_d = br_tgt;
        end else if (taken) begin
            pc_d = b_tgt;
            if (b_ovfl) begin
                tgt_ovfl_d = 1'b1;
            end
        end else begin
            pc_d = pc_plus2;
        end
    end

    // State, PC and sticky flag registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            tgt_ovfl_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_ovfl_q <= tgt_ovfl_d;
        end
    end

    assign pc       = pc_q;
    assign halted   = (state_q == HALTED);
    assign tgt_ovfl = tgt_ovfl_q;

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: expected PCs are queued when stimulus
// is applied and popped/compared after the clock edge.
module tb_pc_control;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch;
    logic        branch_reg;
    logic [2:0]  cond;
    logic [8:0]  imm9;
    logic [15:0] reg_tgt;
    logic [2:0]  flags;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        taken;
    logic        halted;
    logic        tgt_ovfl;

    int checks;
    int errors;
    logic [15:0] exp_q[$];
    logic [15:0] exp_pc;

    pc_control #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .branch     (branch),
        .branch_reg (branch_reg),
        .cond       (cond),
        .imm9       (imm9),
        .reg_tgt    (reg_tgt),
        .flags      (flags),
        .halt       (halt),
        .pc         (pc),
        .pc_plus2   (pc_plus2),
        .taken      (taken),
        .halted     (halted),
        .tgt_ovfl   (tgt_ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall      = 1'b0;
        branch     = 1'b0;
        branch_reg = 1'b0;
        cond       = 3'b000;
        imm9       = 9'h000;
        reg_tgt    = 16'h0000;
        flags      = 3'b000;
        halt       = 1'b0;
    endtask

    // Positions the PC with an unconditional register branch
    task automatic jump_to(input logic [15:0] addr);
        idle_inputs();
        branch_reg = 1'b1;
        cond       = 3'b111;
        reg_tgt    = addr;
        step();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 16'h0000 || halted !== 1'b0 || tgt_ovfl !== 1'b0 || pc_plus2 !== 16'h0002) begin
            errors++;
            $display("FAIL reset_state: pc=%h pc_plus2=%h halted=%b ovfl=%b, want 0000 0002 0 0",
                     pc, pc_plus2, halted, tgt_ovfl);
        end
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0006);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc = exp_q.pop_front();
            checks++;
            if (pc !== exp_pc || halted !== 1'b0 || tgt_ovfl !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle%0d: pc=%h halted=%b ovfl=%b, want pc=%h 0 0",
                         i, pc, halted, tgt_ovfl, exp_pc);
            end
            $display("idle cycle %0d: pc=%h", i, pc);
        end
    endtask

    task automatic test_branch_rel();
        jump_to(16'h0010);
        branch = 1'b1; cond = 3'b001; flags = 3'b100; imm9 = 9'h004;
        #1;
        checks++;
        if (taken !== 1'b1) begin
            errors++;
            $display("FAIL b_eq_taken: taken=%b want 1", taken);
        end
        exp_q.push_back(16'h001A);
        step();
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc) begin
            errors++;
            $display("FAIL b_eq_target: pc=%h want %h", pc, exp_pc);
        end
        $display("B EQ Z=1 from 0010: pc=%h", pc);

        jump_to(16'h0010);
        branch = 1'b1; cond = 3'b001; flags = 3'b000; imm9 = 9'h004;
        #1;
        checks++;
        if (taken !== 1'b0) begin
            errors++;
            $display("FAIL b_eq_not_taken: taken=%b want 0", taken);
        end
        exp_q.push_back(16'h0012);
        step();
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc) begin
            errors++;
            $display("FAIL b_eq_fallthrough: pc=%h want %h", pc, exp_pc);
        end
        $display("B EQ Z=0 from 0010: pc=%h", pc);
        idle_inputs();
    endtask

    task automatic test_overflow();
        jump_to(16'h7FFC);
        branch = 1'b1; cond = 3'b111; imm9 = 9'h0FF;
        exp_q.push_back(16'h81FC);
        step();
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc || tgt_ovfl !== 1'b1) begin
            errors++;
            $display("FAIL ovfl_set: pc=%h ovfl=%b, want %h 1", pc, tgt_ovfl, exp_pc);
        end
        $display("B overflow from 7FFC: pc=%h ovfl=%b", pc, tgt_ovfl);
        idle_inputs();
        step();
        step();
        checks++;
        if (tgt_ovfl !== 1'b1) begin
            errors++;
            $display("FAIL ovfl_sticky: ovfl=%b want 1", tgt_ovfl);
        end

        do_reset();
        branch = 1'b1; cond = 3'b111; imm9 = 9'h1FF;
        exp_q.push_back(16'h0000);
        step();
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc || tgt_ovfl !== 1'b0) begin
            errors++;
            $display("FAIL b_neg_no_ovfl: pc=%h ovfl=%b, want %h 0", pc, tgt_ovfl, exp_pc);
        end
        $display("B imm=-1 from 0000: pc=%h ovfl=%b", pc, tgt_ovfl);
        idle_inputs();
    endtask

    task automatic test_stall();
        jump_to(16'h0100);
        branch_reg = 1'b1; cond = 3'b111; reg_tgt = 16'h1235; stall = 1'b1;
        #1;
        checks++;
        if (taken !== 1'b0) begin
            errors++;
            $display("FAIL stall_taken: taken=%b want 0", taken);
        end
        exp_q.push_back(16'h0100);
        step();
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc) begin
            errors++;
            $display("FAIL stall_hold: pc=%h want %h", pc, exp_pc);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (taken !== 1'b1) begin
            errors++;
            $display("FAIL br_taken: taken=%b want 1", taken);
        end
        exp_q.push_back(16'h1234);
        step();
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc) begin
            errors++;
            $display("FAIL br_target: pc=%h want %h", pc, exp_pc);
        end
        $display("BR after stall: pc=%h", pc);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        // Both branch kinds asserted: register branch wins
        jump_to(16'h0020);
        branch = 1'b1; branch_reg = 1'b1; cond = 3'b111; imm9 = 9'h004; reg_tgt = 16'h0300;
        exp_q.push_back(16'h0300);
        step();
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc) begin
            errors++;
            $display("FAIL br_priority: pc=%h want %h", pc, exp_pc);
        end
        // Immediately followed by a backward relative branch: 0302 - 8 = 02FA
        branch_reg = 1'b0; imm9 = 9'h1FC;
        exp_q.push_back(16'h02FA);
        step();
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc || tgt_ovfl !== 1'b0) begin
            errors++;
            $display("FAIL b_backward: pc=%h ovfl=%b want %h 0", pc, tgt_ovfl, exp_pc);
        end
        $display("back-to-back branches: pc=%h", pc);
        idle_inputs();
    endtask

    task automatic test_wrap();
        jump_to(16'hFFFE);
        exp_q.push_back(16'h0000);
        step();
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc || tgt_ovfl !== 1'b0) begin
            errors++;
            $display("FAIL seq_wrap: pc=%h ovfl=%b want %h 0", pc, tgt_ovfl, exp_pc);
        end
        $display("sequential wrap: pc=%h", pc);
    endtask

    task automatic test_halt();
        // halt during stall is ignored
        jump_to(16'h0040);
        halt = 1'b1; stall = 1'b1;
        step();
        checks++;
        if (halted !== 1'b0 || pc !== 16'h0040) begin
            errors++;
            $display("FAIL halt_stalled: halted=%b pc=%h want 0 0040", halted, pc);
        end
        stall = 1'b0;
        step();
        checks++;
        if (halted !== 1'b1 || pc !== 16'h0040) begin
            errors++;
            $display("FAIL halt_enter: halted=%b pc=%h want 1 0040", halted, pc);
        end
        for (int i = 0; i < 5; i++) begin
            branch_reg = 1'b1; cond = 3'b111; reg_tgt = 16'h0100; halt = i[0];
            #1;
            checks++;
            if (taken !== 1'b0) begin
                errors++;
                $display("FAIL halted_taken%0d: taken=%b want 0", i, taken);
            end
            exp_q.push_back(16'h0040);
            step();
            exp_pc = exp_q.pop_front();
            checks++;
            if (pc !== exp_pc || halted !== 1'b1) begin
                errors++;
                $display("FAIL halted_hold%0d: pc=%h halted=%b want %h 1", i, pc, halted, exp_pc);
            end
            $display("halted cycle %0d: pc=%h", i, pc);
        end
        do_reset();
        checks++;
        if (pc !== 16'h0000 || halted !== 1'b0 || tgt_ovfl !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: pc=%h halted=%b ovfl=%b want 0000 0 0", pc, halted, tgt_ovfl);
        end
    endtask

    task automatic test_cond_sweep();
        logic exp_t;
        logic z, v, n;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                z = f[2]; v = f[1]; n = f[0];
                case (c)
                    0: exp_t = !z;
                    1: exp_t = z;
                    2: exp_t = !z && !n;
                    3: exp_t = n;
                    4: exp_t = z || (!z && !n);
                    5: exp_t = n || z;
                    6: exp_t = v;
                    default: exp_t = 1'b1;
                endcase
                idle_inputs();
                branch = 1'b1; cond = c[2:0]; flags = f[2:0];
                #1;
                checks++;
                if (taken !== exp_t) begin
                    errors++;
                    $display("FAIL cond_sweep c=%0d f=%03b: taken=%b want %b", c, f[2:0], taken, exp_t);
                end
                $display("cond=%0d flags=%03b taken=%b", c, f[2:0], taken);
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_branch_rel();
        test_overflow();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_halt();
        test_cond_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
